// File: rtl/cmp_sched_pkg.sv
// rtl/cmp_sched_pkg.sv - shared constants and helpers for the comparator scheduler
package cmp_sched_pkg;

    localparam int CMP_W     = 32;
    localparam int N_REQ_MAX = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp32.sv
// rtl/cmp32.sv - 32-bit equality comparator
module cmp32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        y
);

    assign y = (a == b);

endmodule

// File: rtl/cmp32_rr_sched_rr_pick.sv
// rtl/cmp32_rr_sched_rr_pick.sv - rotating-mask round-robin priority picker
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] ge_ptr;
    logic [N-1:0] hi;
    logic [N-1:0] sel;

    // Mask of requesters at or above the pointer; they outrank wrapped ones.
    always_comb begin
        ge_ptr = '0;
        for (int i = 0; i < N; i++) begin
            ge_ptr[i] = (i >= int'(ptr));
        end
    end

    assign hi     = valid & ge_ptr;
    assign sel    = (|hi) ? hi : valid;
    assign onehot = sel & (~sel + N'(1));
    assign any    = |valid;

    // Encode the isolated lowest set bit into an index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/cmp32_rr_sched.sv
// rtl/cmp32_rr_sched.sv - round-robin time-shared 32-bit equality comparator
module cmp32_rr_sched
    import cmp_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*CMP_W-1:0] req_a,
    input  logic [N_REQ*CMP_W-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_eq,
    output logic [ID_W-1:0]        rsp_id
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_any;
    logic             can_accept;
    logic             grant;
    logic [CMP_W-1:0] op_a;
    logic [CMP_W-1:0] op_b;
    logic             cmp_y;

    rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The slot can take a new result when empty or being drained this cycle.
    assign can_accept = !rsp_valid || rsp_ready;
    assign grant      = can_accept && !flush && pick_any;
    assign req_ready  = grant ? pick_onehot : '0;

    // Steer the granted requester's operands into the single comparator.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                op_a = req_a[i*CMP_W +: CMP_W];
                op_b = req_b[i*CMP_W +: CMP_W];
            end
        end
    end

    cmp32 u_cmp (
        .a (op_a),
        .b (op_b),
        .y (cmp_y)
    );

    // Response slot: flush kills it, a grant (re)loads it, a drain empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_id    <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_eq    <= cmp_y;
            rsp_id    <= pick_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner on each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
        end
    end

endmodule
